// File: rtl/sort_mux_arb.sv
// rtl/sort_mux_arb.sv - N-channel select/arbitrate mux into a registered one-word output stage
// Define SORT_MUX_ARB_RR_EN for round-robin arbitration; default build is fixed priority (lowest index wins).
module sort_mux_arb #(
  parameter int DATAWIDTH = 32,
  parameter int NUM_CH    = 4,
  parameter int CHW       = 2
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic [NUM_CH*DATAWIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]           in_valid,
  output logic [NUM_CH-1:0]           in_ready,
  input  logic                        force_en,
  input  logic [CHW-1:0]              force_ch,
  output logic [DATAWIDTH-1:0]        out_data,
  output logic [CHW-1:0]              out_ch,
  output logic                        out_valid,
  input  logic                        out_ready
);

  logic [DATAWIDTH-1:0] out_data_q, out_data_d;
  logic [CHW-1:0]       out_ch_q, out_ch_d;
  logic                 out_valid_q, out_valid_d;

  logic [NUM_CH-1:0]    search;
  logic [NUM_CH-1:0]    grant_oh;
  logic [CHW-1:0]       grant_idx;
  logic [DATAWIDTH-1:0] sel_data;
  logic                 load_ok;
  logic                 in_xfer;

`ifdef SORT_MUX_ARB_RR_EN
  logic [CHW-1:0]    ptr_q, ptr_d;
  logic [NUM_CH-1:0] hi_valid;
`endif

  // Candidate set: forced channel only, or every valid channel rotated by the pointer.
  always_comb begin
    search = '0;
`ifdef SORT_MUX_ARB_RR_EN
    hi_valid = '0;
`endif
    if (force_en) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (int'(force_ch) == i) search[i] = in_valid[i];
      end
    end else begin
`ifdef SORT_MUX_ARB_RR_EN
      for (int i = 0; i < NUM_CH; i++) begin
        if (i >= int'(ptr_q)) hi_valid[i] = in_valid[i];
      end
      search = (|hi_valid) ? hi_valid : in_valid;
`else
      search = in_valid;
`endif
    end
  end

  always_comb begin
    grant_oh = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (search[i]) begin
        grant_oh    = '0;
        grant_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    grant_idx = '0;
    sel_data  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_oh[i]) begin
        grant_idx = CHW'(i);
        sel_data  = in_data[i*DATAWIDTH +: DATAWIDTH];
      end
    end
  end

  assign load_ok  = !out_valid_q || out_ready;
  assign in_ready = (Rst || !load_ok) ? '0 : grant_oh;
  assign in_xfer  = |(in_ready & in_valid);

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    if (in_xfer) begin
      out_data_d  = sel_data;
      out_ch_d    = grant_idx;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

`ifdef SORT_MUX_ARB_RR_EN
  always_comb begin
    ptr_d = ptr_q;
    if (in_xfer) ptr_d = (int'(grant_idx) == NUM_CH - 1) ? '0 : grant_idx + CHW'(1);
  end
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
`ifdef SORT_MUX_ARB_RR_EN
      ptr_q       <= '0;
`endif
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
`ifdef SORT_MUX_ARB_RR_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule
